axi_lite_master_bridge: RTL and testbench

- Initiator end of the UART AXI4 link. The peripheral wrapper on that link is the responder.
- Converts a simple single-word request/response port, of the kind the core's data path uses, into single-beat AXI4 read and write transactions.
- Sits between the core's MMIO decode and the UART wrapper's io_uart_* channel set.
- One transaction outstanding at a time.

---
 rtl/axi_pkg.sv | 10 +
 rtl/axi_lite_master_bridge.sv | 136 +++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 constants and the bridge FSM state encoding shared by the UART link initiator.
package axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
endpackage

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: turns single-word requests into single-beat AXI4 reads/writes, one at a time.
module axi_lite_master_bridge
    import axi_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int TXN_ID = 0,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ID_W-1:0]   ar_id,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ID_W-1:0]   r_id,
    input  logic [1:0]        r_resp,
    input  logic [31:0]       r_data,
    input  logic              r_last,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ID_W-1:0]   aw_id,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic [2:0]        aw_size,
    output logic [1:0]        aw_burst,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [31:0]       w_data,
    output logic [3:0]        w_strb,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ID_W-1:0]   b_id,
    input  logic [1:0]        b_resp
);
    localparam logic [ID_W-1:0] TID = ID_W'(TXN_ID);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wmask_q;

    assign ar_id    = TID;
    assign ar_addr  = addr_q;
    assign ar_len   = 8'd0;
    assign ar_size  = AXI_SIZE_4B;
    assign ar_burst = AXI_BURST_INCR;
    assign aw_id    = TID;
    assign aw_addr  = addr_q;
    assign aw_len   = 8'd0;
    assign aw_size  = AXI_SIZE_4B;
    assign aw_burst = AXI_BURST_INCR;
    assign w_data   = wdata_q;
    assign w_strb   = wmask_q;
    assign w_last   = 1'b1;

    // aw_valid / w_valid double as the per-channel pending flags while in WR_REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                IDLE: if (req_en) begin
                    addr_q     <= req_addr;
                    wdata_q    <= req_wdata;
                    wmask_q    <= req_wmask;
                    req_ready  <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    ar_valid   <= !req_we;
                    aw_valid   <= req_we;
                    w_valid    <= req_we;
                    state      <= req_we ? WR_REQ : RD_ADDR;
                end
                RD_ADDR: if (ar_ready) begin
                    ar_valid <= 1'b0;
                    r_ready  <= 1'b1;
                    state    <= RD_DATA;
                end
                RD_DATA: if (r_valid) begin
                    r_ready    <= 1'b0;
                    resp_rdata <= r_data;
                    resp_err   <= (r_resp != AXI_RESP_OKAY) || !r_last || (r_id != TID);
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                WR_REQ: begin
                    if (aw_ready) aw_valid <= 1'b0;
                    if (w_ready) w_valid <= 1'b0;
                    if ((!aw_valid || aw_ready) && (!w_valid || w_ready)) begin
                        b_ready <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: if (b_valid) begin
                    b_ready    <= 1'b0;
                    resp_err   <= (b_resp != AXI_RESP_OKAY) || (b_id != TID);
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: directed and random requests against a delay-configurable AXI responder and a spec-level model.
module tb_axi_lite_master_bridge;
    import axi_pkg::*;
    localparam int TXN_ID = 60;
    localparam logic [7:0] TID = 8'(TXN_ID);

    logic clk = 0, rst = 1;
    logic req_en = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0] req_wmask = 0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [7:0] ar_id, r_id, ar_len, aw_len, aw_id, b_id;
    logic [31:0] ar_addr, aw_addr, r_data, w_data;
    logic [2:0] ar_size, aw_size;
    logic [1:0] ar_burst, aw_burst, r_resp, b_resp;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [3:0] w_strb;

    axi_lite_master_bridge #(.ID_W(8), .TXN_ID(TXN_ID), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_resp(r_resp),
        .r_data(r_data), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    // responder configuration, written by the stimulus between transactions
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] r_data_v = 0;
    logic [1:0] r_resp_v = AXI_RESP_OKAY, b_resp_v = AXI_RESP_OKAY;
    logic [7:0] r_id_v = TID, b_id_v = TID;
    logic r_last_v = 1;

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, aw_seen, w_seen, b_pend;
    logic ar_hs_c, aw_hs_c, w_hs_c;

    assign ar_ready = ar_valid && ar_cnt >= ar_dly;
    assign aw_ready = aw_valid && aw_cnt >= aw_dly;
    assign w_ready  = w_valid && w_cnt >= w_dly;
    assign r_valid  = r_pend && r_cnt >= r_dly;
    assign b_valid  = b_pend && b_cnt >= b_dly;
    assign r_data = r_data_v;
    assign r_resp = r_resp_v;
    assign r_id   = r_id_v;
    assign r_last = r_last_v;
    assign b_resp = b_resp_v;
    assign b_id   = b_id_v;
    assign ar_hs_c = ar_valid && ar_ready;
    assign aw_hs_c = aw_valid && aw_ready;
    assign w_hs_c  = w_valid && w_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 0; aw_seen <= 0; w_seen <= 0; b_pend <= 0;
        end else begin
            ar_cnt <= (ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
            aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
            w_cnt  <= (w_valid && !w_ready) ? w_cnt + 1 : 0;
            if (ar_hs_c) begin r_pend <= 1; r_cnt <= 0; end
            else if (r_valid && r_ready) r_pend <= 0;
            else if (r_pend) r_cnt <= r_cnt + 1;
            if ((aw_seen || aw_hs_c) && (w_seen || w_hs_c)) begin
                b_pend <= 1; b_cnt <= 0; aw_seen <= 0; w_seen <= 0;
            end else begin
                if (aw_hs_c) aw_seen <= 1;
                if (w_hs_c) w_seen <= 1;
                if (b_valid && b_ready) b_pend <= 0;
                else if (b_pend) b_cnt <= b_cnt + 1;
            end
        end
    end

    // handshake capture and cycle bookkeeping
    int cyc = 0, ar_hs = 0, aw_hs = 0, w_hs = 0, resp_cnt = 0, aw_cyc = 0, w_cyc = 0;
    logic [31:0] ar_addr_s, aw_addr_s, w_data_s;
    logic [7:0] ar_len_s, aw_len_s, ar_id_s, aw_id_s;
    logic [2:0] ar_size_s, aw_size_s;
    logic [1:0] ar_burst_s, aw_burst_s;
    logic [3:0] w_strb_s;
    logic w_last_s;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (ar_hs_c) begin
            ar_hs <= ar_hs + 1; ar_addr_s <= ar_addr; ar_len_s <= ar_len;
            ar_size_s <= ar_size; ar_burst_s <= ar_burst; ar_id_s <= ar_id;
        end
        if (aw_hs_c) begin
            aw_hs <= aw_hs + 1; aw_addr_s <= aw_addr; aw_len_s <= aw_len; aw_cyc <= cyc;
            aw_size_s <= aw_size; aw_burst_s <= aw_burst; aw_id_s <= aw_id;
        end
        if (w_hs_c) begin
            w_hs <= w_hs + 1; w_data_s <= w_data; w_strb_s <= w_strb; w_last_s <= w_last; w_cyc <= cyc;
        end
    end

    // a valid that was waiting must still be up, with the same payload, one cycle later
    int stab_viol = 0;
    logic arp, awp, wp;
    logic [31:0] ar_addr_p, aw_addr_p, w_data_p;
    logic [3:0] w_strb_p;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arp <= 0; awp <= 0; wp <= 0;
        end else begin
            stab_viol <= stab_viol + int'(arp && (ar_valid !== 1'b1 || ar_addr !== ar_addr_p))
                                   + int'(awp && (aw_valid !== 1'b1 || aw_addr !== aw_addr_p))
                                   + int'(wp && (w_valid !== 1'b1 || w_data !== w_data_p || w_strb !== w_strb_p));
            arp <= ar_valid && !ar_ready; ar_addr_p <= ar_addr;
            awp <= aw_valid && !aw_ready; aw_addr_p <= aw_addr;
            wp <= w_valid && !w_ready; w_data_p <= w_data; w_strb_p <= w_strb;
        end
    end

    int errors = 0, checks = 0;
    int snap_ar, snap_aw, snap_w, snap_rc, t_acc, t_resp;
    logic [1:0] err_codes [3] = '{AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic start_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        snap_ar = ar_hs; snap_aw = aw_hs; snap_w = w_hs; snap_rc = resp_cnt;
        req_en = 1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        @(posedge clk);
        @(negedge clk);
        req_en = 0;
        t_acc = cyc;
        chk("req_ready_drop", 32'(req_ready), 32'd0);
    endtask

    task automatic finish_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit zw);
        int n = 0;
        logic [31:0] er;
        logic ee;
        er = we ? 32'd0 : r_data_v;
        ee = we ? (b_resp_v != AXI_RESP_OKAY || b_id_v != TID)
                : (r_resp_v != AXI_RESP_OKAY || r_last_v != 1'b1 || r_id_v != TID);
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        t_resp = cyc;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, er);
        chk("resp_err", 32'(resp_err), 32'(ee));
        if (zw) chk("latency", 32'(t_resp - t_acc), 32'd2);
        @(negedge clk);
        chk("resp_pulse_len", 32'(resp_valid), 32'd0);
        chk("resp_count", 32'(resp_cnt - snap_rc), 32'd1);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        chk("ar_hs_count", 32'(ar_hs - snap_ar), we ? 32'd0 : 32'd1);
        chk("aw_hs_count", 32'(aw_hs - snap_aw), we ? 32'd1 : 32'd0);
        chk("w_hs_count", 32'(w_hs - snap_w), we ? 32'd1 : 32'd0);
        chk("stability", 32'(stab_viol), 32'd0);
        if (we) begin
            chk("aw_addr", aw_addr_s, a);
            chk("aw_fixed", {aw_id_s, aw_len_s, 5'd0, aw_size_s, 6'd0, aw_burst_s}, {TID, 8'd0, 5'd0, 3'b010, 6'd0, 2'b01});
            chk("w_data", w_data_s, d);
            chk("w_strb_last", {27'd0, w_strb_s, w_last_s}, {27'd0, m, 1'b1});
        end else begin
            chk("ar_addr", ar_addr_s, a);
            chk("ar_fixed", {ar_id_s, ar_len_s, 5'd0, ar_size_s, 6'd0, ar_burst_s}, {TID, 8'd0, 5'd0, 3'b010, 6'd0, 2'b01});
        end
    endtask

    task automatic set_ok(input int d_ar, input int d_r, input int d_aw, input int d_w, input int d_b);
        ar_dly = d_ar; r_dly = d_r; aw_dly = d_aw; w_dly = d_w; b_dly = d_b;
        r_resp_v = AXI_RESP_OKAY; r_last_v = 1; r_id_v = TID;
        b_resp_v = AXI_RESP_OKAY; b_id_v = TID;
    endtask

    initial begin
        int t_first;
        logic we;
        logic [31:0] a, d;
        logic [3:0] m;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_valids", {26'd0, ar_valid, r_ready, aw_valid, w_valid, b_ready, resp_valid}, 32'd0);
        chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
        chk("rst_latched", ar_addr | w_data | 32'(w_strb), 32'd0);
        rst = 0;
        @(negedge clk);

        set_ok(0, 0, 0, 0, 0);
        r_data_v = 32'h00000041;
        start_txn(0, 32'hBFD003F8, 0, 0);
        finish_txn(0, 32'hBFD003F8, 0, 0, 1);

        set_ok(0, 0, 3, 0, 0);
        start_txn(1, 32'h10000004, 32'h55, 4'b0001);
        chk("wr_entry_valids", {30'd0, aw_valid, w_valid}, 32'd3);
        @(negedge clk);
        chk("w_drops_first", {30'd0, aw_valid, w_valid}, 32'd2);
        finish_txn(1, 32'h10000004, 32'h55, 4'b0001, 0);
        chk("w_hs_cycle", 32'(w_cyc - t_acc), 32'd0);
        chk("aw_hs_cycle", 32'(aw_cyc - t_acc), 32'd3);

        set_ok(10, 0, 0, 0, 0);
        r_data_v = 32'h12345678;
        start_txn(0, 32'hA5A50010, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ar_valid", 32'(ar_valid), 32'd1);
            chk("bp_ar_addr", ar_addr, 32'hA5A50010);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            req_en = i[0]; req_we = 1; req_addr = $urandom();
            @(negedge clk);
        end
        req_en = 0;
        finish_txn(0, 32'hA5A50010, 0, 0, 0);

        set_ok(0, 0, 0, 0, 0);
        r_resp_v = AXI_RESP_SLVERR; r_data_v = 32'hDEADBEEF;
        start_txn(0, 32'h00000100, 0, 0);
        finish_txn(0, 32'h00000100, 0, 0, 1);

        set_ok(0, 0, 0, 0, 0);
        b_id_v = TID + 8'd1;
        start_txn(1, 32'h00000200, 32'hCAFEF00D, 4'b1111);
        finish_txn(1, 32'h00000200, 32'hCAFEF00D, 4'b1111, 1);

        set_ok(0, 5, 0, 0, 0);
        start_txn(0, 32'h00000300, 0, 0);
        n = 0;
        while (!r_ready && n < 50) begin @(negedge clk); n++; end
        chk("rd_data_reached", 32'(r_ready), 32'd1);
        chk("r_ready_before_valid", 32'(r_valid), 32'd0);
        snap_rc = resp_cnt;
        #1 rst = 1;
        #1;
        chk("abort_valids", {29'd0, r_ready, ar_valid, resp_valid}, 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("abort_no_resp", 32'(resp_cnt - snap_rc), 32'd0);
        set_ok(0, 0, 0, 0, 0);
        r_data_v = 32'h0BADC0DE;
        start_txn(0, 32'h00000304, 0, 0);
        finish_txn(0, 32'h00000304, 0, 0, 1);

        set_ok(0, 0, 0, 0, 0);
        r_data_v = 32'h77;
        start_txn(0, 32'h00000400, 0, 0);
        finish_txn(0, 32'h00000400, 0, 0, 1);
        t_first = t_resp;
        start_txn(1, 32'h00000404, 32'h99, 4'b0110);
        finish_txn(1, 32'h00000404, 32'h99, 4'b0110, 1);
        chk("b2b_spacing", 32'(t_resp - t_first), 32'd4);

        for (int k = 0; k < 24; k++) begin
            int kind;
            set_ok($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            a = $urandom(); d = $urandom(); m = 4'($urandom()); r_data_v = $urandom();
            kind = $urandom_range(0, 3);
            if (kind == 2) begin
                r_resp_v = err_codes[$urandom_range(0, 2)];
                b_resp_v = err_codes[$urandom_range(0, 2)];
            end else if (kind == 3) begin
                if ($urandom_range(0, 1) == 1) r_last_v = 0; else r_id_v = TID ^ 8'h01;
                b_id_v = TID + 8'd1;
            end
            start_txn(we, a, d, m);
            finish_txn(we, a, d, m, ar_dly + r_dly + aw_dly + w_dly + b_dly == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
